// File: rtl/regfile_pkg.sv
// Shared constants and the one-hot validity helper for the register file
// and its write-select decoder.
package regfile_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int NREGS     = 32;
  localparam int ADDR_W    = 5;

  function automatic logic is_onehot32(input logic [31:0] sel);
    return (sel != 32'd0) && ((sel & (sel - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/register_file32_reg_en.sv
// WIDTH-bit storage register with asynchronous active-low clear and load enable.
module reg_en #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  // Load on enable, clear asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= {WIDTH{1'b0}};
    end else if (en_i) begin
      q_q <= d_i;
    end else begin
      q_q <= q_q;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/register_file32.sv
// 32 x WIDTH register file driven by a one-hot write select, with r0 hardwired
// to zero, write-first bypass on both read ports and a sticky malformed-select flag.
module register_file32
  import regfile_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                RegWrite,
  input  logic [NREGS-1:0]    WriteSel,
  input  logic [WIDTH-1:0]    WriteData,
  input  logic [ADDR_W-1:0]   ReadReg1,
  input  logic [ADDR_W-1:0]   ReadReg2,
  output logic [WIDTH-1:0]    ReadData1,
  output logic [WIDTH-1:0]    ReadData2,
  output logic                sel_err
);

  logic [WIDTH-1:0] regs_s [NREGS];
  logic             sel_valid_s;
  logic             wr_ok_s;
  logic             byp1_s;
  logic             byp2_s;
  logic             sel_err_q;
  logic             sel_err_d;

  assign sel_valid_s = is_onehot32(WriteSel);
  assign wr_ok_s     = RegWrite & sel_valid_s & rst_n;

  assign regs_s[0] = {WIDTH{1'b0}};

  for (genvar k = 1; k < NREGS; k++) begin : g_reg
    reg_en #(.WIDTH(WIDTH)) u_reg (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .en_i   (RegWrite & sel_valid_s & WriteSel[k]),
      .d_i    (WriteData),
      .q_o    (regs_s[k])
    );
  end

  // A pending valid write to a nonzero register wins over stored data.
  assign byp1_s = wr_ok_s & WriteSel[ReadReg1] & (ReadReg1 != {ADDR_W{1'b0}});
  assign byp2_s = wr_ok_s & WriteSel[ReadReg2] & (ReadReg2 != {ADDR_W{1'b0}});

  // Read port 1 mux.
  always_comb begin
    ReadData1 = {WIDTH{1'b0}};
    if (!rst_n) begin
      ReadData1 = {WIDTH{1'b0}};
    end else if (byp1_s) begin
      ReadData1 = WriteData;
    end else begin
      ReadData1 = regs_s[ReadReg1];
    end
  end

  // Read port 2 mux.
  always_comb begin
    ReadData2 = {WIDTH{1'b0}};
    if (!rst_n) begin
      ReadData2 = {WIDTH{1'b0}};
    end else if (byp2_s) begin
      ReadData2 = WriteData;
    end else begin
      ReadData2 = regs_s[ReadReg2];
    end
  end

  // Sticky error next state: set on any requested write with a malformed select.
  always_comb begin
    sel_err_d = sel_err_q;
    if (RegWrite && !sel_valid_s) begin
      sel_err_d = 1'b1;
    end else begin
      sel_err_d = sel_err_q;
    end
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_register_file32.sv
// Directed self-checking bench for register_file32.
module tb_register_file32;

  logic        clk;
  logic        rst_n;
  logic        RegWrite;
  logic [31:0] WriteSel;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        sel_err;

  int total;
  int bad;

  register_file32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .RegWrite  (RegWrite),
    .WriteSel  (WriteSel),
    .WriteData (WriteData),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .sel_err   (sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Drive a write request, take one rising edge, then drop the request.
  task automatic wr(input logic [31:0] sel, input logic [31:0] data);
    RegWrite  = 1'b1;
    WriteSel  = sel;
    WriteData = data;
    @(posedge clk);
    #1;
    RegWrite  = 1'b0;
    WriteSel  = 32'h0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    RegWrite = 1'b0;
    WriteSel = 32'h0;
    WriteData = 32'h0;
    ReadReg1 = 5'd0;
    ReadReg2 = 5'd0;

    // Reset state
    #2;
    chk("rst_rd1", ReadData1, 32'h0);
    chk("rst_rd2", ReadData2, 32'h0);
    chk("rst_err", {31'b0, sel_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic write/read
    wr(32'h0000_0008, 32'hDEAD_BEEF);
    ReadReg1 = 5'd3;
    ReadReg2 = 5'd4;
    #1;
    chk("basic_r3", ReadData1, 32'hDEAD_BEEF);
    chk("basic_r4", ReadData2, 32'h0);

    // Bypass, before and after the edge
    wr(32'h0000_0080, 32'h0000_0001);
    ReadReg1 = 5'd7;
    ReadReg2 = 5'd7;
    #1;
    chk("pre_r7", ReadData1, 32'h0000_0001);
    RegWrite = 1'b1;
    WriteSel = 32'h0000_0080;
    WriteData = 32'hA5A5_A5A5;
    #1;
    chk("byp_rd1", ReadData1, 32'hA5A5_A5A5);
    chk("byp_rd2", ReadData2, 32'hA5A5_A5A5);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    WriteSel = 32'h0;
    WriteData = 32'h0;
    #1;
    chk("post_rd1", ReadData1, 32'hA5A5_A5A5);
    chk("post_rd2", ReadData2, 32'hA5A5_A5A5);

    // r0 protection: no bypass, no store, no error
    ReadReg1 = 5'd0;
    ReadReg2 = 5'd0;
    RegWrite = 1'b1;
    WriteSel = 32'h0000_0001;
    WriteData = 32'hFFFF_FFFF;
    #1;
    chk("r0_nobyp", ReadData1, 32'h0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    WriteSel = 32'h0;
    #1;
    chk("r0_read", ReadData2, 32'h0);
    chk("r0_err", {31'b0, sel_err}, 32'h0);

    // Gate check: RegWrite low ignores WriteSel
    ReadReg1 = 5'd3;
    WriteData = 32'h0000_0123;
    WriteSel = 32'h0;
    @(posedge clk);
    #1;
    chk("gate_err", {31'b0, sel_err}, 32'h0);
    chk("gate_r3", ReadData1, 32'hDEAD_BEEF);

    // Asynchronous reset mid-cycle
    wr(32'h0000_0020, 32'h0000_1234);
    ReadReg1 = 5'd5;
    #1;
    chk("r5_pre", ReadData1, 32'h0000_1234);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_r5", ReadData1, 32'h0);
    chk("arst_err", {31'b0, sel_err}, 32'h0);
    // Writes blocked and no bypass during reset
    ReadReg2 = 5'd9;
    RegWrite = 1'b1;
    WriteSel = 32'h0000_0200;
    WriteData = 32'h0000_9999;
    #1;
    chk("rst_nobyp", ReadData2, 32'h0);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    WriteSel = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_blk_r9", ReadData2, 32'h0);

    // Malformed select
    wr(32'h0000_0002, 32'h0000_0011);
    wr(32'h0000_0004, 32'h0000_0022);
    ReadReg1 = 5'd1;
    ReadReg2 = 5'd2;
    RegWrite = 1'b1;
    WriteSel = 32'h0000_0006;
    WriteData = 32'h0000_0055;
    #1;
    chk("bad_nobyp1", ReadData1, 32'h0000_0011);
    chk("bad_nobyp2", ReadData2, 32'h0000_0022);
    @(posedge clk);
    #1;
    RegWrite = 1'b0;
    WriteSel = 32'h0;
    #1;
    chk("bad_r1", ReadData1, 32'h0000_0011);
    chk("bad_r2", ReadData2, 32'h0000_0022);
    chk("bad_err", {31'b0, sel_err}, 32'h1);
    wr(32'h0000_0008, 32'h0000_0077);
    ReadReg1 = 5'd3;
    #1;
    chk("sticky_r3", ReadData1, 32'h0000_0077);
    chk("sticky_err", {31'b0, sel_err}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("err_clr", {31'b0, sel_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero select with RegWrite is also malformed
    #1;
    wr(32'h0000_0000, 32'h0000_00AA);
    chk("zero_sel_err", {31'b0, sel_err}, 32'h1);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Sweep all writable registers, then read back on both ports
    for (int k = 1; k < 32; k++) begin
      wr(32'h1 << k, k);
    end
    for (int k = 1; k < 32; k++) begin
      ReadReg1 = k[4:0];
      ReadReg2 = k[4:0];
      #1;
      chk($sformatf("sweep1_r%0d", k), ReadData1, k);
      chk($sformatf("sweep2_r%0d", k), ReadData2, k);
    end
    chk("sweep_err", {31'b0, sel_err}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
